// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared constants, FSM state type and packing helper for the systolic feed sequencer
package systolic_pkg;

    localparam int ARRAY_N      = 3;
    localparam int CLEAR_CYCLES = 2;
    localparam int FEED_LAST    = 6;
    localparam int EN_LAST      = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ARM,
        S_FEED,
        S_CAPTURE,
        S_DONE
    } state_t;

    // Flat element index of (row i, column j) in a packed 3x3 matrix.
    function automatic logic [3:0] pack_idx(input logic [1:0] i, input logic [1:0] j);
        return 4'(ARRAY_N) * {2'b00, i} + {2'b00, j};
    endfunction

endpackage

// File: rtl/systolic_feed_ctrl_if.sv
// rtl/systolic_feed_ctrl_if.sv - job request, operand, PE feedback and array-drive signals of the feed sequencer
// slave modport: sequencer side (START, A_MAT, B_MAT, PE_SUM, PE_OVF in; array drive and result out)
// master modport: requester/array side, the mirror image
interface systolic_feed_ctrl_if #(
    parameter int WIDTH     = 4,
    parameter int WIDTH_SUM = 8
);
    logic                   START;
    logic [9*WIDTH-1:0]     A_MAT;
    logic [9*WIDTH-1:0]     B_MAT;
    logic [9*WIDTH_SUM-1:0] PE_SUM;
    logic [8:0]             PE_OVF;
    logic                   ARRAY_RST_N;
    logic                   ARRAY_EN;
    logic [3*WIDTH-1:0]     A_ROW;
    logic [3*WIDTH-1:0]     B_COL;
    logic [9*WIDTH_SUM-1:0] C_MAT;
    logic                   OVF;
    logic                   BUSY;
    logic                   DONE;

    modport slave (
        input  START, A_MAT, B_MAT, PE_SUM, PE_OVF,
        output ARRAY_RST_N, ARRAY_EN, A_ROW, B_COL, C_MAT, OVF, BUSY, DONE
    );

    modport master (
        output START, A_MAT, B_MAT, PE_SUM, PE_OVF,
        input  ARRAY_RST_N, ARRAY_EN, A_ROW, B_COL, C_MAT, OVF, BUSY, DONE
    );
endinterface

// File: rtl/systolic_skew_sel.sv
// rtl/systolic_skew_sel.sv - picks the diagonally skewed operand element for one feed lane
// Ports: cnt (feed step), lane (lane index), mat (packed 3x3 operand), lane_val (element or 0).
// ROW_LANE=1: lane is a row of A, element A(lane, cnt-lane); ROW_LANE=0: lane is a column of B, element B(cnt-lane, lane).
module systolic_skew_sel
    import systolic_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter bit ROW_LANE = 1'b1
) (
    input  logic [2:0]         cnt,
    input  logic [1:0]         lane,
    input  logic [9*WIDTH-1:0] mat,
    output logic [WIDTH-1:0]   lane_val
);

    logic [2:0] diff;
    logic [3:0] idx;

    always_comb begin
        lane_val = '0;
        idx      = '0;
        diff     = cnt - {1'b0, lane};
        if ((cnt >= {1'b0, lane}) && (diff < 3'(ARRAY_N))) begin
            idx      = ROW_LANE ? pack_idx(lane, diff[1:0]) : pack_idx(diff[1:0], lane);
            lane_val = mat[idx*WIDTH +: WIDTH];
        end
    end

endmodule

// File: rtl/systolic_feed_ctrl.sv
// rtl/systolic_feed_ctrl.sv - job sequencer for a 3x3 output-stationary systolic multiplier array
// Ports: CLK, RST (sync, active high); bus (slave modport): START/A_MAT/B_MAT job request,
// PE_SUM/PE_OVF array feedback, ARRAY_RST_N/ARRAY_EN/A_ROW/B_COL array drive, C_MAT/OVF/BUSY/DONE result.
// Optional feature: define SYSTOLIC_FEED_CTRL_OVF_EN to register the OR of PE_OVF into OVF; otherwise OVF is 0.
module systolic_feed_ctrl
    import systolic_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int WIDTH_SUM = 8
) (
    input logic                 CLK,
    input logic                 RST,
    systolic_feed_ctrl_if.slave bus
);

    state_t state, state_nx;
    logic [2:0] cnt, cnt_nx;
    logic       load_ops;

    logic [9*WIDTH-1:0]     a_op, b_op;
    logic [WIDTH-1:0]       a_lane [ARRAY_N];
    logic [WIDTH-1:0]       b_lane [ARRAY_N];

    logic                   rst_n_d, en_d, busy_d, done_d;
    logic [3*WIDTH-1:0]     a_row_d, b_col_d;

    logic                   rst_n_r, en_r, busy_r, done_r;
    logic [3*WIDTH-1:0]     a_row_r, b_col_r;
    logic [9*WIDTH_SUM-1:0] c_r;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        load_ops = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                state_nx = S_IDLE;
                if (bus.START) begin
                    load_ops = 1'b1;
                    state_nx = S_CLEAR;
                    cnt_nx   = '0;
                end
            end
            S_CLEAR: begin
                if (cnt == 3'(CLEAR_CYCLES - 1)) begin
                    state_nx = S_ARM;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 3'd1;
                end
            end
            S_ARM: begin
                state_nx = S_FEED;
                cnt_nx   = '0;
            end
            S_FEED: begin
                if (cnt == 3'(FEED_LAST)) begin
                    state_nx = S_CAPTURE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 3'd1;
                end
            end
            S_CAPTURE: state_nx = S_DONE;
            default:   state_nx = S_IDLE;
        endcase
    end

    // Lane selectors look at the next step so the registered lanes line up with the FEED cycle.
    for (genvar g = 0; g < ARRAY_N; g++) begin : g_lane
        systolic_skew_sel #(.WIDTH(WIDTH), .ROW_LANE(1'b1)) u_a_sel (
            .cnt      (cnt_nx),
            .lane     (2'(g)),
            .mat      (a_op),
            .lane_val (a_lane[g])
        );
        systolic_skew_sel #(.WIDTH(WIDTH), .ROW_LANE(1'b0)) u_b_sel (
            .cnt      (cnt_nx),
            .lane     (2'(g)),
            .mat      (b_op),
            .lane_val (b_lane[g])
        );
    end

    // Output decode from the upcoming state, so every output is a plain register.
    // ARM enables the array one cycle early because the PE registers its ENABLE.
    always_comb begin
        rst_n_d = (state_nx != S_CLEAR);
        en_d    = (state_nx == S_ARM) ||
                  ((state_nx == S_FEED) && (cnt_nx <= 3'(EN_LAST)));
        busy_d  = (state_nx == S_CLEAR) || (state_nx == S_ARM) ||
                  (state_nx == S_FEED)  || (state_nx == S_CAPTURE);
        done_d  = (state_nx == S_DONE);
        a_row_d = '0;
        b_col_d = '0;
        if (state_nx == S_FEED) begin
            for (int i = 0; i < ARRAY_N; i++) begin
                a_row_d[i*WIDTH +: WIDTH] = a_lane[i];
                b_col_d[i*WIDTH +: WIDTH] = b_lane[i];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            a_op    <= '0;
            b_op    <= '0;
            rst_n_r <= 1'b1;
            en_r    <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            a_row_r <= '0;
            b_col_r <= '0;
            c_r     <= '0;
        end else begin
            if (load_ops) begin
                a_op <= bus.A_MAT;
                b_op <= bus.B_MAT;
            end
            rst_n_r <= rst_n_d;
            en_r    <= en_d;
            busy_r  <= busy_d;
            done_r  <= done_d;
            a_row_r <= a_row_d;
            b_col_r <= b_col_d;
            if (state == S_CAPTURE) begin
                c_r <= bus.PE_SUM;
            end
        end
    end

`ifdef SYSTOLIC_FEED_CTRL_OVF_EN
    logic ovf_r;
    always_ff @(posedge CLK) begin
        if (RST) begin
            ovf_r <= 1'b0;
        end else if (state == S_CAPTURE) begin
            ovf_r <= |bus.PE_OVF;
        end
    end
    assign bus.OVF = ovf_r;
`else
    assign bus.OVF = 1'b0;
`endif

    assign bus.ARRAY_RST_N = rst_n_r;
    assign bus.ARRAY_EN    = en_r;
    assign bus.A_ROW       = a_row_r;
    assign bus.B_COL       = b_col_r;
    assign bus.C_MAT       = c_r;
    assign bus.BUSY        = busy_r;
    assign bus.DONE        = done_r;

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// tb/tb_systolic_feed_ctrl.sv - self-checking bench for systolic_feed_ctrl with a behavioural 3x3 PE array
module tb_systolic_feed_ctrl;

    localparam int W  = 4;
    localparam int WS = 8;

`ifdef SYSTOLIC_FEED_CTRL_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    systolic_feed_ctrl_if #(.WIDTH(W), .WIDTH_SUM(WS)) bus ();

    systolic_feed_ctrl #(.WIDTH(W), .WIDTH_SUM(WS)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    // Behavioural PE array: registered ENABLE, accumulate and pass operands right/down.
    logic [W-1:0]  pe_a [3][3];
    logic [W-1:0]  pe_b [3][3];
    logic [W-1:0]  a_in [3][3];
    logic [W-1:0]  b_in [3][3];
    logic [WS-1:0] pe_s [3][3];
    logic [WS:0]   s_nx [3][3];
    logic          pe_o [3][3];
    logic          pe_en;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            a_in[i][0] = bus.A_ROW[i*W +: W];
            b_in[0][i] = bus.B_COL[i*W +: W];
        end
        for (int i = 0; i < 3; i++) begin
            for (int j = 1; j < 3; j++) begin
                a_in[i][j] = pe_a[i][j-1];
                b_in[j][i] = pe_b[j-1][i];
            end
        end
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                s_nx[i][j] = {1'b0, pe_s[i][j]} + ({5'b0, a_in[i][j]} * {5'b0, b_in[i][j]});
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!bus.ARRAY_RST_N) begin
            pe_en <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    pe_a[i][j] <= '0;
                    pe_b[i][j] <= '0;
                    pe_s[i][j] <= '0;
                    pe_o[i][j] <= 1'b0;
                end
            end
        end else begin
            pe_en <= bus.ARRAY_EN;
            if (pe_en) begin
                for (int i = 0; i < 3; i++) begin
                    for (int j = 0; j < 3; j++) begin
                        pe_a[i][j] <= a_in[i][j];
                        pe_b[i][j] <= b_in[i][j];
                        pe_s[i][j] <= s_nx[i][j][WS-1:0];
                        pe_o[i][j] <= pe_o[i][j] | s_nx[i][j][WS];
                    end
                end
            end
        end
    end

    always_comb begin
        bus.PE_SUM = '0;
        bus.PE_OVF = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                bus.PE_SUM[(3*i+j)*WS +: WS] = pe_s[i][j];
                bus.PE_OVF[3*i+j]            = pe_o[i][j];
            end
        end
    end

    typedef struct {
        logic [35:0] a;
        logic [35:0] b;
        logic [71:0] c;
        logic        ovf;
        bit          skew;
    } vec_t;

    vec_t vecs [4];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_rst_n"}, 72'(bus.ARRAY_RST_N), 72'd1);
        chk({nm, "_en"},    72'(bus.ARRAY_EN),    72'd0);
        chk({nm, "_a_row"}, 72'(bus.A_ROW),       72'd0);
        chk({nm, "_b_col"}, 72'(bus.B_COL),       72'd0);
        chk({nm, "_c_mat"}, bus.C_MAT,            72'd0);
        chk({nm, "_ovf"},   72'(bus.OVF),         72'd0);
        chk({nm, "_busy"},  72'(bus.BUSY),        72'd0);
        chk({nm, "_done"},  72'(bus.DONE),        72'd0);
    endtask

    task automatic do_job(input vec_t v, input string nm);
        int   done_at;
        int   busy_bad;
        int   rstn_bad;
        int   c;
        logic [W-1:0] exp_lane;
        @(negedge clk);
        bus.A_MAT = v.a;
        bus.B_MAT = v.b;
        bus.START = 1'b1;
        done_at   = -1;
        busy_bad  = 0;
        rstn_bad  = 0;
        for (int k = 1; k <= 30 && done_at < 0; k++) begin
            @(negedge clk);
            if (k == 1) bus.START = 1'b0;
            if (bus.DONE) done_at = k;
            if (bus.BUSY !== (k <= 11)) busy_bad++;
            if (bus.ARRAY_RST_N !== !(k == 1 || k == 2)) rstn_bad++;
            if (v.skew && k >= 4 && k <= 10) begin
                c = k - 4;
                for (int i = 0; i < 3; i++) begin
                    exp_lane = (c >= i && c - i <= 2) ? W'(i + 1) : W'(0);
                    chk($sformatf("%s_a_row%0d_cnt%0d", nm, i, c), 72'(bus.A_ROW[i*W +: W]), 72'(exp_lane));
                    chk($sformatf("%s_b_col%0d_cnt%0d", nm, i, c), 72'(bus.B_COL[i*W +: W]), 72'(exp_lane));
                end
                chk($sformatf("%s_en_cnt%0d", nm, c), 72'(bus.ARRAY_EN), 72'(c <= 5));
            end
        end
        chk({nm, "_done_cycle"}, 72'(done_at), 72'd12);
        chk({nm, "_busy"},       72'(busy_bad), 72'd0);
        chk({nm, "_array_rst"},  72'(rstn_bad), 72'd0);
        chk({nm, "_c_mat"},      bus.C_MAT,     v.c);
        chk({nm, "_ovf"},        72'(bus.OVF),  72'(v.ovf));
        @(negedge clk);
        chk({nm, "_done_pulse"}, 72'(bus.DONE), 72'd0);
        chk({nm, "_c_hold"},     bus.C_MAT,     v.c);
    endtask

    initial begin
        int first_done;
        int second_done;
        int done_cnt;
        logic [71:0] c_first;

        vecs[0] = '{a: 36'h100010001, b: 36'h987654321, c: 72'h09_08_07_06_05_04_03_02_01, ovf: 1'b0, skew: 1'b0};
        vecs[1] = '{a: 36'h333222111, b: 36'h321321321, c: 72'h1B_12_09_12_0C_06_09_06_03, ovf: 1'b0, skew: 1'b1};
        vecs[2] = '{a: 36'hFFFFFFFFF, b: 36'hFFFFFFFFF, c: 72'hA3_A3_A3_A3_A3_A3_A3_A3_A3, ovf: OVF_ON, skew: 1'b0};
        vecs[3] = '{a: 36'h987654321, b: 36'h987654321, c: 72'h96_7E_66_60_51_42_2A_24_1E, ovf: 1'b0, skew: 1'b0};

        rst       = 1'b1;
        bus.START = 1'b0;
        bus.A_MAT = '0;
        bus.B_MAT = '0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset_held");
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("reset_released");

        for (int v = 0; v < 4; v++) begin
            do_job(vecs[v], $sformatf("vec%0d", v));
        end

        // START held across a whole job: one job, then a second accepted in the DONE cycle.
        @(negedge clk);
        bus.A_MAT   = vecs[0].a;
        bus.B_MAT   = vecs[0].b;
        bus.START   = 1'b1;
        first_done  = -1;
        second_done = -1;
        done_cnt    = 0;
        c_first     = '0;
        for (int k = 1; k <= 30 && second_done < 0; k++) begin
            @(negedge clk);
            if (k == 5) begin
                bus.A_MAT = vecs[3].a;
                bus.B_MAT = vecs[3].b;
            end
            if (k == 13) bus.START = 1'b0;
            if (bus.DONE) begin
                done_cnt++;
                if (first_done < 0) begin
                    first_done = k;
                    c_first    = bus.C_MAT;
                end else begin
                    second_done = k;
                end
            end
        end
        chk("hold_first_done",  72'(first_done),  72'd12);
        chk("hold_first_c",     c_first,          vecs[0].c);
        chk("hold_second_done", 72'(second_done), 72'd24);
        chk("hold_second_c",    bus.C_MAT,        vecs[3].c);
        chk("hold_done_count",  72'(done_cnt),    72'd2);
        @(negedge clk);

        // Reset in the middle of a job, then a clean job with no residue.
        @(negedge clk);
        bus.A_MAT = vecs[2].a;
        bus.B_MAT = vecs[2].b;
        bus.START = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) bus.START = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs("abort");
        rst = 1'b0;
        @(negedge clk);
        do_job(vecs[0], "after_abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/systolic_feed_ctrl.md
# systolic_feed_ctrl

Sequencer for the 3x3 output-stationary systolic multiplier built from `PROCESS_ELEMENT` tiles. It latches two 3x3 operand matrices on a start request and clears the array. It then drives the diagonally skewed A rows into the left column and B columns into the top row, gates the array `ENABLE`, and captures the nine PE sums into a result register with a done pulse.

## Interface
- `WIDTH`, 4, operand element width (matches PE `WIDTH`)
- `WIDTH_SUM`, 8, accumulator width (matches PE `WIDTH_SUM`)
- `CLK` in 1, the single clock for the block
- `RST` in 1, synchronous, active-high reset
- `START` in 1, job request; sampled only when idle
- `A_MAT` in 9*WIDTH, A(i,j) at bits [(3i+j)*WIDTH +: WIDTH]
- `B_MAT` in 9*WIDTH, B(i,j), same packing
- `PE_SUM` in 9*WIDTH_SUM, PE(i,j) `SUM`, packed as (3i+j)
- `PE_OVF` in 9, PE(i,j) `MULTI_OVER`, bit (3i+j)
- `ARRAY_RST_N` out 1, active-low reset to all PEs
- `ARRAY_EN` out 1, `ENABLE` to all PEs
- `A_ROW` out 3*WIDTH, lane i feeds `A_IN` of PE(i,0)
- `B_COL` out 3*WIDTH, lane j feeds `B_IN` of PE(0,j)
- `C_MAT` out 9*WIDTH_SUM, captured result, packed as (3i+j)
- `OVF` out 1, overflow summary (see Configuration)
- `BUSY` out 1, job in progress
- `DONE` out 1, one-cycle result-valid pulse

## Operation
- FSM states: IDLE, CLEAR, ARM, FEED, CAPTURE, DONE. A 3-bit counter `cnt` counts cycles within CLEAR and FEED.
- **IDLE:**
  - On `START`=1, latch `A_MAT`/`B_MAT` into internal operand registers.
  - Go to CLEAR with `cnt`=0.
- **CLEAR:** 2 cycles.
  - `ARRAY_RST_N`=0, `ARRAY_EN`=0, lanes 0.
  - Go to ARM.
- **ARM:** 1 cycle.
  - `ARRAY_EN`=1, lanes 0. This compensates for the PE's registered state (enable at cycle t takes effect on the edge ending t+1).
  - Go to FEED with `cnt`=0.
- **FEED:** `cnt` = 0..6.
  - `A_ROW`[i] = A(i, cnt-i) when 0 ≤ cnt-i ≤ 2, else 0.
  - `B_COL`[j] = B(cnt-j, j) when 0 ≤ cnt-j ≤ 2, else 0.
  - `ARRAY_EN`=1 for cnt 0..5 and 0 at cnt=6.
  - After cnt=6, go to CAPTURE.
- **CAPTURE:** 1 cycle.
  - Load `C_MAT` from `PE_SUM`.
  - Load the overflow register.
  - Go to DONE.
- **DONE:** 1 cycle.
  - `DONE`=1.
  - Behaves as IDLE for `START`: a `START` here is accepted and goes to CLEAR. Otherwise go to IDLE.
- `START` in any other state is ignored. The latched operands are held for the whole job.
- Arithmetic is performed only in the PEs. `C_MAT` holds each PE's sum modulo 2^WIDTH_SUM.

## Timing
- Cycle 0 is the cycle `START` is accepted.
  - CLEAR: cycles 1–2.
  - ARM: cycle 3.
  - FEED: cycles 4–10.
  - CAPTURE: cycle 11.
  - DONE: cycle 12, with `C_MAT` valid from cycle 12.
- Latency is 12 cycles from START to DONE. Back-to-back throughput is one job per 12 cycles.
- `BUSY`=1 in cycles 1–11. `BUSY`=0 in IDLE and DONE.
- All outputs are registered.
- Reset values: `ARRAY_RST_N`=1, `ARRAY_EN`=0, `A_ROW`=0, `B_COL`=0, `C_MAT`=0, `OVF`=0, `BUSY`=0, `DONE`=0. FSM resets to IDLE and `cnt` to 0.
- `RST` mid-job aborts immediately: all outputs take their reset values on the next edge. A later job re-clears the array through CLEAR, so no stale PE state survives.
- `C_MAT` and `OVF` hold their value until the next CAPTURE.

## Configuration
- Macro: `SYSTOLIC_FEED_CTRL_OVF_EN`.
- Defined: `OVF` is loaded in CAPTURE with the OR of all nine `PE_OVF` bits.
- Undefined: the `PE_OVF` input is unused and `OVF` is constant 0. No overflow register is instantiated.

## Structure
- Package `systolic_pkg` holds:
  - the FSM state enum;
  - `ARRAY_N`=3;
  - `CLEAR_CYCLES`=2;
  - `FEED_LAST`=6;
  - `EN_LAST`=5;
  - the packing-index helper (3i+j).
- One sub-module, `systolic_skew_sel`: combinational. Inputs are `cnt`, the lane index and a packed operand matrix. Output is one lane value. It is instantiated 3× for A and 3× for B.

## Test plan
- A = identity, B = {1..9} row-major, `START` pulse:
  - `DONE` at cycle 12;
  - `C_MAT` = {1..9};
  - `OVF`=0.
- A(i,j)=i+1, B(i,j)=j+1 → C(i,j)=3(i+1)(j+1), e.g. C(2,2)=27.
  - Check `A_ROW`/`B_COL` skew values in every FEED cycle.
- All elements 15:
  - every C = 163 (675 mod 256);
  - `OVF`=1 with the macro defined, 0 without.
- `START` held high during cycles 1–11:
  - exactly one job runs;
  - a second job starts from the DONE cycle and gives its own correct result.
- `RST` asserted at cycle 6 of a job:
  - next cycle all outputs are at reset values;
  - a new `START` then gives the correct `C_MAT` with no residue from the aborted job.
